// File: rtl/mul_accum.sv
// mul_accum: sums groups of N consecutive unsigned 8-bit products and
// presents each group total, a sticky carry flag and the group index on a
// valid/ready output port. Two states: ACC gathers products, HOLD keeps the
// finished result stable until the sink takes it.
module mul_accum #(
    parameter int N     = 4,   // products summed per group (N >= 2)
    parameter int ACC_W = 12,  // accumulator / result width (ACC_W >= 8)
    parameter int CNT_W = 8    // group-index counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_prod,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_grp
);

    // Position counter only has to reach N-1.
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [IDX_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;
    logic [CNT_W-1:0]   grp_reg, grp_next;
    logic [ACC_W-1:0]   sum_reg, sum_next;
    logic               out_ovf_reg, out_ovf_next;
    logic               valid_reg, valid_next;
    logic [CNT_W-1:0]   out_grp_reg, out_grp_next;

    // One extra bit on the adder so the carry out of ACC_W bits is visible.
    logic [ACC_W:0]     add_full;
    logic               add_carry;
    logic [ACC_W-1:0]   add_wrap;
    logic               last_item;

    // Zero-extended add of the incoming product onto the running sum.
    assign add_full  = {1'b0, acc_reg} + {{(ACC_W + 1 - 8){1'b0}}, in_prod};
    assign add_carry = add_full[ACC_W];
    assign add_wrap  = add_full[ACC_W-1:0];
    assign last_item = (cnt_reg == LAST_IDX);

    // Input side is open only while gathering; this gives one bubble per group.
    assign in_ready  = (state_reg == ST_ACC);

    assign out_sum   = sum_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_valid = valid_reg;
    assign out_grp   = out_grp_reg;

    // State and datapath registers; reset drops any partial or pending group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_ACC;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            grp_reg     <= '0;
            sum_reg     <= '0;
            out_ovf_reg <= 1'b0;
            valid_reg   <= 1'b0;
            out_grp_reg <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            ovf_reg     <= ovf_next;
            grp_reg     <= grp_next;
            sum_reg     <= sum_next;
            out_ovf_reg <= out_ovf_next;
            valid_reg   <= valid_next;
            out_grp_reg <= out_grp_next;
        end
    end

    // Next-state and datapath logic; everything holds unless a case below acts.
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        ovf_next     = ovf_reg;
        grp_next     = grp_reg;
        sum_next     = sum_reg;
        out_ovf_next = out_ovf_reg;
        valid_next   = valid_reg;
        out_grp_next = out_grp_reg;

        unique case (state_reg)
            ST_ACC: begin
                if (clr) begin
                    // Clear beats a same-cycle product; the group index is kept.
                    acc_next = '0;
                    cnt_next = '0;
                    ovf_next = 1'b0;
                end else if (in_valid) begin
                    if (last_item) begin
                        // Nth product: publish the total and restart the group.
                        sum_next     = add_wrap;
                        out_ovf_next = ovf_reg | add_carry;
                        out_grp_next = grp_reg;
                        valid_next   = 1'b1;
                        acc_next     = '0;
                        cnt_next     = '0;
                        ovf_next     = 1'b0;
                        grp_next     = grp_reg + CNT_W'(1);
                        state_next   = ST_HOLD;
                    end else begin
                        acc_next = add_wrap;
                        ovf_next = ovf_reg | add_carry;
                        cnt_next = cnt_reg + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Result stays put (clr included) until the sink accepts it.
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = ST_ACC;
                end
            end
            default: begin
                state_next = ST_ACC;
            end
        endcase
    end

endmodule
